// File: rtl/alu_pkg.sv
// Shared definitions for the PE integer ALU: the operation encoding and the default datapath width.
package alu_pkg;

    localparam int unsigned ALU_W = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_AND = 1'b1;

endpackage

// File: rtl/alu_comb.sv
// Combinational half of the ALU: computes ADD and AND side by side and selects one of them by op_sel.
module alu_comb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W
) (
    input  logic             op_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] conj;

    // The carry out of the MSB is dropped, so the sum wraps modulo 2**WIDTH.
    assign sum  = a + b;
    assign conj = a & b;

    // An unknown op_sel falls through to the default arm, so X reaches y instead of picking an op.
    always_comb begin
        y = 'x;
        case (op_sel)
            OP_ADD:  y = sum;
            OP_AND:  y = conj;
            default: y = 'x;
        endcase
    end

endmodule

// File: rtl/alu_unit.sv
// Two-function ALU (ADD/AND) for the PE datapath, with one synchronously reset output register.
module alu_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .op_sel (op_sel),
        .a      (a),
        .b      (b),
        .y      (result_d)
    );

    // Reset wins over the operation sampled at the same edge, so that operation is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: a cycle-level reference model plus directed vectors with
// hand-computed results.
module tb_alu_unit;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic         op_sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;

    int errors;
    int checks;

    logic [W-1:0] model_q;
    logic         model_valid;

    alu_unit #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .op_sel (op_sel),
        .a      (a),
        .b      (b),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // What the register must hold after an edge, from the arithmetic definition of each op.
    function automatic logic [W-1:0] expected(input logic r, input logic op,
                                              input logic [W-1:0] x, input logic [W-1:0] y);
        longint unsigned s;
        if (r) return '0;
        if (op == 1'b0) begin
            s = (longint'(x) + longint'(y)) % (64'd1 << W);
            return s[W-1:0];
        end
        return x & y;
    endfunction

    initial model_valid = 1'b0;

    always @(posedge clk) begin
        model_q     <= expected(rst, op_sel, a, b);
        model_valid <= 1'b1;
    end

    // Every cycle after the first edge, the output must match the model.
    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (result !== model_q) begin
                errors++;
                $display("FAIL model_cmp t=%0t: result=%08h required=%08h", $time, result, model_q);
            end
        end
    end

    task automatic check_lit(input string name, input logic [W-1:0] req);
        checks++;
        if (result !== req) begin
            errors++;
            $display("FAIL %s: result=%08h required=%08h", name, result, req);
        end
    endtask

    // Drive inputs away from the edge, let one rising edge capture them, then test the output.
    task automatic step(input string name, input logic r, input logic op,
                        input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] req);
        @(negedge clk);
        rst    = r;
        op_sel = op;
        a      = x;
        b      = y;
        @(posedge clk);
        #1;
        check_lit(name, req);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        op_sel = 1'b0;
        a      = 32'd5;
        b      = 32'd7;

        step("reset_edge1", 1'b1, 1'b0, 32'd5, 32'd7, 32'd0);
        step("reset_edge2", 1'b1, 1'b0, 32'd5, 32'd7, 32'd0);
        step("post_reset_zero", 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);

        step("add_basic", 1'b0, 1'b0, 32'd15, 32'd17, 32'd32);
        step("and_basic", 1'b0, 1'b1, 32'd15, 32'd17, 32'd1);
        step("add_wrap", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0000_0000);
        step("add_wrap_neg", 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0003, 32'h0000_0003);
        step("and_zero", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000);
        step("and_mask", 1'b0, 1'b1, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'hA5A5_0000);
        step("add_mixed", 1'b0, 1'b0, 32'h1234_5678, 32'h0FED_CBA8, 32'h2222_2220);

        // Back-to-back alternation with a one-edge reset dropped into the middle.
        step("b2b_add0", 1'b0, 1'b0, 32'd15, 32'd17, 32'd32);
        step("b2b_and0", 1'b0, 1'b1, 32'd15, 32'd17, 32'd1);
        step("b2b_add1", 1'b0, 1'b0, 32'd15, 32'd17, 32'd32);
        step("b2b_rst", 1'b1, 1'b1, 32'd15, 32'd17, 32'd0);
        step("b2b_add2", 1'b0, 1'b0, 32'd15, 32'd17, 32'd32);
        step("b2b_and1", 1'b0, 1'b1, 32'd15, 32'd17, 32'd1);
        step("b2b_add3", 1'b0, 1'b0, 32'd15, 32'd17, 32'd32);

        // The output must hold between edges: sample again late in the same cycle.
        @(negedge clk);
        op_sel = 1'b1;
        a      = 32'hFFFF_FFFF;
        #3;
        check_lit("hold_between_edges", 32'd32);

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "watchdog");
    end

endmodule
